// File: rtl/la_trace_decoder.sv
// la_trace_decoder: expands run-length-encoded logic-analyzer trace packets
// {rc[31:24], la_data[23:0]} from an AXI-Stream slave port into a
// cycle-by-cycle stream of 24-bit samples with a valid/ready handshake.
// A packet with rc != 0 replays its data for rc cycles. The all-zero packet
// is an overflow marker and produces a single gap sample. A packet with
// rc == 0 and nonzero data is malformed; it is dropped and o_err pulses.
// Optional feature macro: LA_DEC_STATS_EN enables four saturating statistics
// counters. When it is undefined, the stat_* ports are tied to zero.
module la_trace_decoder #(
  parameter int pLA_WIDTH  = 24,
  parameter int pRC_WIDTH  = 8,
  parameter int pCNT_WIDTH = 16
) (
  input  logic                           axis_clk,
  input  logic                           axis_rst_n,
  input  logic                           dec_enable,
  input  logic [pLA_WIDTH+pRC_WIDTH-1:0] s_tdata,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  input  logic                           s_tlast,
  input  logic [1:0]                     s_tuser,
  output logic [pLA_WIDTH-1:0]           o_data,
  output logic                           o_gap,
  output logic                           o_run_last,
  output logic                           o_vld,
  input  logic                           o_rdy,
  output logic                           o_err,
  output logic [pCNT_WIDTH-1:0]          stat_pkt,
  output logic [pCNT_WIDTH-1:0]          stat_gap,
  output logic [pCNT_WIDTH-1:0]          stat_err,
  output logic [pCNT_WIDTH-1:0]          stat_burst
);

  localparam int PKT_W = pLA_WIDTH + pRC_WIDTH;

  logic [pRC_WIDTH-1:0] rem;
  logic [pLA_WIDTH-1:0] hold_data;
  logic                 hold_gap;
  logic                 err_q;

  logic [pRC_WIDTH-1:0] pkt_rc;
  logic [pLA_WIDTH-1:0] pkt_data;
  logic                 pkt_accept;
  logic                 pkt_is_run;
  logic                 pkt_is_null;
  logic                 pkt_is_bad;
  logic                 rem_is_one;
  logic                 sample_take;

  // The sideband user bits carry nothing for this block. s_tlast only feeds
  // the optional burst counter, so it is folded in here as well.
  logic unused_inputs;
  assign unused_inputs = ^{s_tuser, s_tlast};

  assign pkt_rc      = s_tdata[PKT_W-1:pLA_WIDTH];
  assign pkt_data    = s_tdata[pLA_WIDTH-1:0];
  assign pkt_accept  = s_tvalid & s_tready;
  assign pkt_is_run  = (pkt_rc != '0);
  assign pkt_is_null = (pkt_rc == '0) & (pkt_data == '0);
  assign pkt_is_bad  = (pkt_rc == '0) & (pkt_data != '0);
  assign rem_is_one  = (rem == pRC_WIDTH'(1));
  assign sample_take = o_vld & o_rdy;

  // A new packet is taken when the current run is empty, or when its last
  // sample is being consumed this cycle. This gives bubble-free back-to-back
  // runs. While disabled, the input is drained unconditionally.
  assign s_tready = dec_enable ? ((rem == '0) | (rem_is_one & o_rdy)) : 1'b1;

  assign o_vld      = (rem != '0);
  assign o_run_last = rem_is_one;
  assign o_data     = hold_data;
  assign o_gap      = hold_gap;
  assign o_err      = err_q;

  // Run state: a packet load takes priority over the decrement for the
  // consumed sample. Disabling the decoder flushes the run in progress.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      rem       <= '0;
      hold_data <= '0;
      hold_gap  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= dec_enable & pkt_accept & pkt_is_bad;
      if (!dec_enable) begin
        rem <= '0;
      end else if (pkt_accept & pkt_is_run) begin
        hold_data <= pkt_data;
        hold_gap  <= 1'b0;
        rem       <= pkt_rc;
      end else if (pkt_accept & pkt_is_null) begin
        hold_data <= '0;
        hold_gap  <= 1'b1;
        rem       <= pRC_WIDTH'(1);
      end else if (sample_take) begin
        rem <= rem - 1'b1;
      end
    end
  end

`ifdef LA_DEC_STATS_EN
  logic [pCNT_WIDTH-1:0] cnt_pkt;
  logic [pCNT_WIDTH-1:0] cnt_gap;
  logic [pCNT_WIDTH-1:0] cnt_err;
  logic [pCNT_WIDTH-1:0] cnt_burst;

  // Saturating per-class counters. They advance only on accepted beats while
  // the decoder is enabled, so they stay frozen during a flush.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      cnt_pkt   <= '0;
      cnt_gap   <= '0;
      cnt_err   <= '0;
      cnt_burst <= '0;
    end else if (dec_enable & pkt_accept) begin
      if (pkt_is_run && (cnt_pkt != '1))
        cnt_pkt <= cnt_pkt + 1'b1;
      if (pkt_is_null && (cnt_gap != '1))
        cnt_gap <= cnt_gap + 1'b1;
      if (pkt_is_bad && (cnt_err != '1))
        cnt_err <= cnt_err + 1'b1;
      if (s_tlast && (cnt_burst != '1))
        cnt_burst <= cnt_burst + 1'b1;
    end
  end

  assign stat_pkt   = cnt_pkt;
  assign stat_gap   = cnt_gap;
  assign stat_err   = cnt_err;
  assign stat_burst = cnt_burst;
`else
  assign stat_pkt   = '0;
  assign stat_gap   = '0;
  assign stat_err   = '0;
  assign stat_burst = '0;
`endif

endmodule

// File: tb/tb_la_trace_decoder.sv
// tb_la_trace_decoder: self-checking bench for la_trace_decoder. A reference
// model keeps a queue holding the samples that the accepted packets still owe.
// Each test task drives its scenario and compares the logged DUT behaviour
// against the model or against constants taken from the expected replay.
module tb_la_trace_decoder;

  logic        axis_clk = 1'b0;
  logic        axis_rst_n;
  logic        dec_enable;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [1:0]  s_tuser;
  logic [23:0] o_data;
  logic        o_gap;
  logic        o_run_last;
  logic        o_vld;
  logic        o_rdy;
  logic        o_err;
  logic [15:0] stat_pkt;
  logic [15:0] stat_gap;
  logic [15:0] stat_err;
  logic [15:0] stat_burst;

  always #5 axis_clk = ~axis_clk;

  la_trace_decoder #(.pLA_WIDTH(24), .pRC_WIDTH(8), .pCNT_WIDTH(16)) dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .dec_enable (dec_enable),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .s_tuser    (s_tuser),
    .o_data     (o_data),
    .o_gap      (o_gap),
    .o_run_last (o_run_last),
    .o_vld      (o_vld),
    .o_rdy      (o_rdy),
    .o_err      (o_err),
    .stat_pkt   (stat_pkt),
    .stat_gap   (stat_gap),
    .stat_err   (stat_err),
    .stat_burst (stat_burst)
  );

  typedef struct {
    logic [23:0] data;
    logic        gap;
  } sample_t;

  typedef struct {
    logic        vld;
    logic        gap;
    logic        last;
    logic        tready;
    logic        err;
    logic        hs;
    logic        beat;
    logic [23:0] data;
  } cyc_t;

  sample_t q[$];
  cyc_t    obs_log[$];
  cyc_t    exp_log[$];
  int      checks = 0;
  int      errors = 0;
  int      m_pkt, m_gap, m_err, m_burst;

  // Expected value of a statistics port, given the number of events the
  // model has counted.
  function automatic logic [15:0] exp_stat(input int n);
`ifdef LA_DEC_STATS_EN
    return (n > 65535) ? 16'hFFFF : n[15:0];
`else
    return 16'h0 & n[15:0];
`endif
  endfunction

  task automatic model_clear();
    q.delete();
    m_pkt = 0; m_gap = 0; m_err = 0; m_burst = 0;
  endtask

  // Samples the DUT mid-cycle, advances the model across the next rising
  // edge, and logs both the observed and the expected view of this cycle.
  task automatic tick();
    cyc_t ob, ex;
    logic err_next;
    @(negedge axis_clk);
    ob.vld = o_vld; ob.data = o_data; ob.gap = o_gap; ob.last = o_run_last;
    ob.tready = s_tready; ob.hs = o_vld & o_rdy; ob.beat = s_tvalid & s_tready;
    ex.vld    = (q.size() != 0);
    ex.data   = ex.vld ? q[0].data : 24'h0;
    ex.gap    = ex.vld ? q[0].gap : 1'b0;
    ex.last   = (q.size() == 1);
    ex.tready = !dec_enable || (q.size() == 0) || ((q.size() == 1) && o_rdy);
    ex.hs     = ex.vld && o_rdy;
    ex.beat   = s_tvalid && ex.tready;
    err_next  = 1'b0;
    if (!dec_enable) begin
      q.delete();
    end else begin
      if (ex.hs) void'(q.pop_front());
      if (ex.beat) begin
        if (s_tdata == 32'h0) begin
          q.push_back('{data: 24'h0, gap: 1'b1});
          m_gap++;
        end else if (s_tdata[31:24] != 8'h0) begin
          for (int i = 0; i < int'(s_tdata[31:24]); i++)
            q.push_back('{data: s_tdata[23:0], gap: 1'b0});
          m_pkt++;
        end else begin
          err_next = 1'b1;
          m_err++;
        end
        if (s_tlast) m_burst++;
      end
    end
    @(posedge axis_clk);
    #1;
    ob.err = o_err;
    ex.err = err_next;
    obs_log.push_back(ob);
    exp_log.push_back(ex);
  endtask

  // Offers one packet and holds it until the model says it was taken.
  task automatic send_pkt(input logic [31:0] p, input logic last, output bit ok);
    s_tdata = p; s_tvalid = 1'b1; s_tlast = last; ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      tick();
      ok = exp_log[$].beat;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic do_reset();
    axis_rst_n = 1'b0;
    repeat (2) @(posedge axis_clk);
    #1;
    axis_rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    checks++; if (o_vld !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got %0b want 0", o_vld); end
    checks++; if (o_data !== 24'h0) begin errors++; $display("[TB] FAIL reset_data got %0h want 0", o_data); end
    checks++; if (o_gap !== 1'b0) begin errors++; $display("[TB] FAIL reset_gap got %0b want 0", o_gap); end
    checks++; if (o_run_last !== 1'b0) begin errors++; $display("[TB] FAIL reset_last got %0b want 0", o_run_last); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0b want 0", o_err); end
    checks++; if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tready_en got %0b want 1", s_tready); end
    dec_enable = 1'b0;
    #1;
    checks++; if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_tready_dis got %0b want 1", s_tready); end
    dec_enable = 1'b1;
    checks++; if ({stat_pkt, stat_gap, stat_err, stat_burst} !== 64'h0) begin errors++; $display("[TB] FAIL reset_stats got %0h want 0", {stat_pkt, stat_gap, stat_err, stat_burst}); end
  endtask

  task automatic test_single_run();
    bit ok;
    int k;
    o_rdy = 1'b1;
    obs_log.delete(); exp_log.delete();
    send_pkt(32'h03A5A5A5, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_accept got 0 want 1"); end
    k = obs_log.size() - 1;
    repeat (4) tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (obs_log[k+1+i].vld !== 1'b1 || obs_log[k+1+i].data !== 24'hA5A5A5) begin
        errors++; $display("[TB] FAIL single_sample%0d got vld=%0b data=%0h want vld=1 data=a5a5a5", i, obs_log[k+1+i].vld, obs_log[k+1+i].data);
      end
      checks++; if (obs_log[k+1+i].last !== (i == 2)) begin
        errors++; $display("[TB] FAIL single_last%0d got %0b want %0b", i, obs_log[k+1+i].last, (i == 2));
      end
    end
    checks++; if (obs_log[k+4].vld !== 1'b0) begin errors++; $display("[TB] FAIL single_end_vld got %0b want 0", obs_log[k+4].vld); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pk[4];
    logic [23:0] want_d[5];
    logic        want_g[5];
    int          hsidx[$];
    bit          ok;
    pk = '{32'h02000001, 32'h01000002, 32'h00000000, 32'h01000003};
    want_d = '{24'h1, 24'h1, 24'h2, 24'h0, 24'h3};
    want_g = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    o_rdy = 1'b1;
    obs_log.delete(); exp_log.delete();
    for (int i = 0; i < 4; i++) begin
      send_pkt(pk[i], 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_accept%0d got 0 want 1", i); end
    end
    repeat (3) tick();
    foreach (obs_log[i]) if (obs_log[i].hs) hsidx.push_back(i);
    checks++; if (hsidx.size() != 5) begin errors++; $display("[TB] FAIL b2b_count got %0d want 5", hsidx.size()); end
    for (int i = 0; i < 5 && i < hsidx.size(); i++) begin
      checks++; if (obs_log[hsidx[i]].data !== want_d[i] || obs_log[hsidx[i]].gap !== want_g[i]) begin
        errors++; $display("[TB] FAIL b2b_sample%0d got data=%0h gap=%0b want data=%0h gap=%0b", i, obs_log[hsidx[i]].data, obs_log[hsidx[i]].gap, want_d[i], want_g[i]);
      end
      checks++; if (hsidx[i] != hsidx[0] + i) begin errors++; $display("[TB] FAIL b2b_bubble%0d got cycle %0d want %0d", i, hsidx[i], hsidx[0] + i); end
    end
  endtask

  task automatic test_backpressure();
    logic pat[7];
    int   hs_cnt;
    int   k;
    bit   ok;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    o_rdy = 1'b1;
    obs_log.delete(); exp_log.delete();
    send_pkt(32'h0400FF00, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_accept got 0 want 1"); end
    k = obs_log.size();
    s_tdata = 32'h01000009; s_tvalid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      o_rdy = pat[i];
      tick();
    end
    s_tvalid = 1'b0; o_rdy = 1'b1;
    tick(); tick();
    hs_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      if (obs_log[k+i].hs) hs_cnt++;
      checks++; if (obs_log[k+i].vld !== 1'b1 || obs_log[k+i].data !== 24'h00FF00) begin
        errors++; $display("[TB] FAIL bp_hold%0d got vld=%0b data=%0h want vld=1 data=00ff00", i, obs_log[k+i].vld, obs_log[k+i].data);
      end
      checks++; if (obs_log[k+i].tready !== (i == 6)) begin
        errors++; $display("[TB] FAIL bp_tready%0d got %0b want %0b", i, obs_log[k+i].tready, (i == 6));
      end
    end
    checks++; if (hs_cnt != 4) begin errors++; $display("[TB] FAIL bp_handshakes got %0d want 4", hs_cnt); end
    checks++; if (obs_log[k+7].vld !== 1'b1 || obs_log[k+7].data !== 24'h9 || obs_log[k+7].last !== 1'b1) begin
      errors++; $display("[TB] FAIL bp_next got vld=%0b data=%0h last=%0b want vld=1 data=9 last=1", obs_log[k+7].vld, obs_log[k+7].data, obs_log[k+7].last);
    end
    checks++; if (obs_log[k+8].vld !== 1'b0) begin errors++; $display("[TB] FAIL bp_drain got %0b want 0", obs_log[k+8].vld); end
  endtask

  task automatic test_malformed_max();
    int  k, n_hs, n_last, last_pos, hs_pos;
    bit  ok;
    o_rdy = 1'b1;
    obs_log.delete(); exp_log.delete();
    send_pkt(32'h00000010, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bad_accept got 0 want 1"); end
    k = obs_log.size() - 1;
    tick(); tick();
    checks++; if (obs_log[k].err !== 1'b1) begin errors++; $display("[TB] FAIL bad_err_pulse got %0b want 1", obs_log[k].err); end
    checks++; if (obs_log[k+1].err !== 1'b0) begin errors++; $display("[TB] FAIL bad_err_clear got %0b want 0", obs_log[k+1].err); end
    checks++; if (obs_log[k+1].vld !== 1'b0 || obs_log[k+2].vld !== 1'b0) begin errors++; $display("[TB] FAIL bad_no_vld got %0b want 0", obs_log[k+1].vld | obs_log[k+2].vld); end
    obs_log.delete(); exp_log.delete();
    send_pkt(32'hFF123456, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL max_accept got 0 want 1"); end
    repeat (260) tick();
    n_hs = 0; n_last = 0; last_pos = -1; hs_pos = -1;
    foreach (obs_log[i]) begin
      if (obs_log[i].hs && obs_log[i].data === 24'h123456 && obs_log[i].gap === 1'b0) begin
        n_hs++; hs_pos = i;
      end
      if (obs_log[i].last) begin n_last++; last_pos = i; end
    end
    checks++; if (n_hs != 255) begin errors++; $display("[TB] FAIL max_count got %0d want 255", n_hs); end
    checks++; if (n_last != 1 || last_pos != hs_pos) begin errors++; $display("[TB] FAIL max_last got count=%0d at %0d want count=1 at %0d", n_last, last_pos, hs_pos); end
  endtask

  task automatic test_flush();
    logic [31:0] dis_pk[3];
    int          k, n_hs;
    bit          ok;
    dis_pk = '{32'h02000011, 32'h00000022, 32'h00000000};
    o_rdy = 1'b1;
    obs_log.delete(); exp_log.delete();
    send_pkt(32'h080000AB, 1'b0, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL flush_accept got 0 want 1"); end
    repeat (3) tick();
    dec_enable = 1'b0;
    tick();
    k = obs_log.size();
    for (int i = 0; i < 3; i++) begin
      send_pkt(dis_pk[i], 1'b1, ok);
      checks++; if (!ok || obs_log[$].tready !== 1'b1) begin errors++; $display("[TB] FAIL flush_drain%0d got tready=%0b want 1", i, obs_log[$].tready); end
    end
    tick();
    for (int i = k; i < obs_log.size(); i++) begin
      checks++; if (obs_log[i].vld !== 1'b0 || obs_log[i].err !== 1'b0) begin
        errors++; $display("[TB] FAIL flush_quiet%0d got vld=%0b err=%0b want 0 0", i - k, obs_log[i].vld, obs_log[i].err);
      end
    end
    dec_enable = 1'b1;
    k = obs_log.size();
    send_pkt(32'h01000007, 1'b0, ok);
    repeat (3) tick();
    n_hs = 0;
    for (int i = k; i < obs_log.size(); i++) begin
      if (obs_log[i].hs) begin
        n_hs++;
        checks++; if (obs_log[i].data !== 24'h7) begin errors++; $display("[TB] FAIL flush_resume_data got %0h want 7", obs_log[i].data); end
      end
    end
    checks++; if (n_hs != 1) begin errors++; $display("[TB] FAIL flush_resume_count got %0d want 1", n_hs); end
  endtask

  task automatic test_reset_midrun();
    bit ok;
    o_rdy = 1'b1;
    send_pkt(32'h0A000042, 1'b0, ok);
    tick(); tick();
    checks++; if (o_vld !== 1'b1) begin errors++; $display("[TB] FAIL midrun_active got %0b want 1", o_vld); end
    axis_rst_n = 1'b0;
    #1;
    checks++; if (o_vld !== 1'b0 || o_data !== 24'h0) begin errors++; $display("[TB] FAIL midrun_clear got vld=%0b data=%0h want 0 0", o_vld, o_data); end
    checks++; if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL midrun_tready got %0b want 1", s_tready); end
    @(posedge axis_clk);
    #1;
    axis_rst_n = 1'b1;
    model_clear();
    tick();
    checks++; if (obs_log[$].vld !== 1'b0) begin errors++; $display("[TB] FAIL midrun_after got %0b want 0", obs_log[$].vld); end
  endtask

  task automatic test_stats();
    logic [31:0] pk[6];
    logic        lst[6];
    bit          ok;
    pk  = '{32'h02000001, 32'h00000000, 32'h01000002, 32'h00000005, 32'h00000000, 32'h03000003};
    lst = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    o_rdy = 1'b1;
    for (int i = 0; i < 6; i++) send_pkt(pk[i], lst[i], ok);
    repeat (5) tick();
`ifdef LA_DEC_STATS_EN
    checks++; if (stat_pkt !== 16'd3) begin errors++; $display("[TB] FAIL stats_pkt got %0d want 3", stat_pkt); end
    checks++; if (stat_gap !== 16'd2) begin errors++; $display("[TB] FAIL stats_gap got %0d want 2", stat_gap); end
    checks++; if (stat_err !== 16'd1) begin errors++; $display("[TB] FAIL stats_err got %0d want 1", stat_err); end
    checks++; if (stat_burst !== 16'd2) begin errors++; $display("[TB] FAIL stats_burst got %0d want 2", stat_burst); end
`else
    checks++; if ({stat_pkt, stat_gap, stat_err, stat_burst} !== 64'h0) begin errors++; $display("[TB] FAIL stats_tied got %0h want 0", {stat_pkt, stat_gap, stat_err, stat_burst}); end
`endif
  endtask

  task automatic test_random();
    int   pick;
    cyc_t ob, ex;
    for (int c = 0; c < 3000; c++) begin
      dec_enable = ($urandom_range(0, 99) >= 3);
      o_rdy      = ($urandom_range(0, 99) < 75);
      s_tvalid   = ($urandom_range(0, 99) < 60);
      s_tlast    = 1'($urandom);
      s_tuser    = 2'($urandom);
      pick       = int'($urandom_range(0, 99));
      if (pick < 15)      s_tdata = 32'h0;
      else if (pick < 25) s_tdata = {8'h00, 24'($urandom_range(1, 24'hFFFFFF))};
      else if (pick < 26) s_tdata = {8'hFF, 24'($urandom)};
      else                s_tdata = {8'($urandom_range(1, 4)), 24'($urandom)};
      tick();
      ob = obs_log[$]; ex = exp_log[$];
      checks++; if (ob.vld !== ex.vld) begin errors++; $display("[TB] FAIL rand_vld c%0d got %0b want %0b", c, ob.vld, ex.vld); end
      checks++; if (ob.tready !== ex.tready) begin errors++; $display("[TB] FAIL rand_tready c%0d got %0b want %0b", c, ob.tready, ex.tready); end
      checks++; if (ob.last !== ex.last) begin errors++; $display("[TB] FAIL rand_last c%0d got %0b want %0b", c, ob.last, ex.last); end
      checks++; if (ob.err !== ex.err) begin errors++; $display("[TB] FAIL rand_err c%0d got %0b want %0b", c, ob.err, ex.err); end
      if (ex.vld) begin
        checks++; if (ob.data !== ex.data || ob.gap !== ex.gap) begin
          errors++; $display("[TB] FAIL rand_sample c%0d got data=%0h gap=%0b want data=%0h gap=%0b", c, ob.data, ob.gap, ex.data, ex.gap);
        end
      end
      if (obs_log.size() > 64) begin obs_log.delete(); exp_log.delete(); end
    end
    s_tvalid = 1'b0; dec_enable = 1'b1;
    tick();
    checks++; if (stat_pkt !== exp_stat(m_pkt)) begin errors++; $display("[TB] FAIL rand_stat_pkt got %0d want %0d", stat_pkt, exp_stat(m_pkt)); end
    checks++; if (stat_gap !== exp_stat(m_gap)) begin errors++; $display("[TB] FAIL rand_stat_gap got %0d want %0d", stat_gap, exp_stat(m_gap)); end
    checks++; if (stat_err !== exp_stat(m_err)) begin errors++; $display("[TB] FAIL rand_stat_err got %0d want %0d", stat_err, exp_stat(m_err)); end
    checks++; if (stat_burst !== exp_stat(m_burst)) begin errors++; $display("[TB] FAIL rand_stat_burst got %0d want %0d", stat_burst, exp_stat(m_burst)); end
  endtask

  // Runs every scenario in order and prints the one-line summary.
  initial begin
    dec_enable = 1'b1; s_tdata = 32'h0; s_tvalid = 1'b0; s_tlast = 1'b0;
    s_tuser = 2'b00; o_rdy = 1'b1;
    do_reset();
    $display("[TB] starting la_trace_decoder bench");
    test_reset();
    test_single_run();
    test_back_to_back();
    test_backpressure();
    test_malformed_max();
    test_flush();
    test_reset_midrun();
    test_stats();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
